serial_deserializer: RTL
========================

Name: serial_deserializer

Overview:
- Receive side of the mixed serializer link: collects a 1-bit serial stream into WIDTH-bit parallel words.
- Sits at the far end of the serial line and runs on the fast bit clock, the same clock the serializer's output flop uses.
- Delivers each word through a registered valid/ready interface and holds one completed word while downstream stalls.

Parameters:
- WIDTH, 20, parallel word width; must be >= 2.
- LOGWIDTH, 5, bit-counter width; must satisfy 2**LOGWIDTH >= WIDTH.

Ports:
- clk  input  1  bit clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_i  input  1  serial data bit.
- valid_i  input  1  data_i carries a valid bit this cycle.
- align_i  input  1  synchronous word-boundary restart.
- data_o  output  WIDTH  assembled parallel word.
- valid_o  output  1  data_o holds an unconsumed word.
- ready_i  input  1  downstream accepts data_o this cycle.
- overflow_o  output  1  one-cycle pulse: a completed word was dropped.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: data_o=0, valid_o=0, overflow_o=0, bit counter=0, partial shift register=0, FSM=IDLE.
- Reset mid-word discards the partial word and any held output word.
- Collect FSM, states IDLE and COLLECT:
  - IDLE: counter is 0. valid_i=1 stores data_i as bit 0, sets counter to 1, goes to COLLECT.
  - COLLECT: each cycle with valid_i=1 stores data_i at the counter position and increments the counter.
  - valid_i=0 holds all state; gaps of any length are allowed.
  - Last bit (counter==WIDTH-1 with valid_i=1): word completes, counter wraps to 0, FSM goes to IDLE.
- Bit order: the first received bit goes to data_o[0] (LSB-first).
- Completion latency:
  - The word, including the last bit, is loaded into data_o at the same edge that samples the last bit.
  - valid_o is therefore high in the cycle after the last bit is presented. No combinational path from data_i to data_o.
- Output handshake:
  - A transfer occurs on any edge where valid_o=1 and ready_i=1.
  - While valid_o=1 and ready_i=0, data_o is held stable.
  - valid_o falls after a transfer unless a new word completes on that same edge.
- Simultaneous transfer and completion: the new word loads into data_o, valid_o stays 1, no overflow.
- Full condition: if a word completes while valid_o=1 and ready_i=0:
  - the new word is dropped and the held word is kept;
  - overflow_o=1 for exactly the following cycle.
  - Collection continues normally with the next bit.
- align_i:
  - Clears the counter and the partial word and forces IDLE.
  - If valid_i=1 in the same cycle, that bit becomes bit 0 of a new word (counter goes to 1).
  - align_i has priority over completion: a last bit arriving with align_i does not complete the old word.
  - Never affects data_o or valid_o.
- ready_i is ignored while valid_o=0.

Optional Feature:
- Macro: SERIAL_DESERIALIZER_MSB_FIRST_EN.
- Defined: the first received bit goes to data_o[WIDTH-1], i.e. shift in from the LSB side with the earliest bit ending in the MSB.
- Not defined: LSB-first as specified above.
- Counter, handshake and overflow behaviour are identical in both builds.

Decomposition:
- Package deser_pkg holds:
  - the collect-FSM enum type (IDLE, COLLECT);
  - localparam helper functions for counter width checking.
- One sub-module, deser_bit_counter:
  - LOGWIDTH-wide counter with inc, clear and wrap-at-WIDTH-1;
  - outputs count and a last flag.
- Shift register, output register and handshake stay in serial_deserializer.

Test Plan:
1. Assert reset mid-word, WIDTH=4, after bits 1,0 -> all outputs 0; release, send 1,1,0,0 with ready_i=1 -> data_o=0x3, only that word appears.
2. WIDTH=4, valid_i=1 for 4 cycles with bits 1,0,1,1, ready_i=1 -> valid_o high for exactly 1 cycle, one cycle after the 4th bit, data_o=0xD (MSB_FIRST build: 0xB).
3. Same bits with valid_i low for 3 cycles between each bit -> identical data_o=0xD; counter holds during gaps.
4. ready_i=0, send 0xD then 0x3 -> data_o stays 0xD; overflow_o pulses one cycle after the 0x3 completes; then ready_i=1 -> one transfer of 0xD, valid_o falls.
5. ready_i=1 only on the completion edge of a second word 0x3 while 0xD is held -> data_o becomes 0x3, valid_o stays high, overflow_o stays 0.
6. Send bits 1,1, then align_i=1 with valid_i=1 and data_i=0, then 1,0,1 -> next word 0xA; align_i while valid_o=1 leaves data_o and valid_o unchanged.

Source files
------------

// File: rtl/deser_pkg.sv
// rtl/deser_pkg.sv - shared types and parameter checks for the serial deserializer
package deser_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } collect_state_e;

    function automatic bit counter_width_ok(input int width, input int logwidth);
        return (width >= 2) && ((64'd1 << logwidth) >= 64'(width));
    endfunction

endpackage

// File: rtl/deser_bit_counter.sv
// rtl/deser_bit_counter.sv - bit position counter with clear, increment and wrap at WIDTH-1
module deser_bit_counter #(
    parameter int WIDTH    = 20,
    parameter int LOGWIDTH = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc_i,
    input  logic                clear_i,
    output logic [LOGWIDTH-1:0] count_o,
    output logic                last_o
);

    logic [LOGWIDTH-1:0] count_q;
    logic [LOGWIDTH-1:0] count_d;

    assign last_o  = (count_q == LOGWIDTH'(WIDTH - 1));
    assign count_o = count_q;

    // A clear with a simultaneous increment restarts at position 1: that bit is bit 0.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = inc_i ? LOGWIDTH'(1) : '0;
        end else if (inc_i) begin
            count_d = last_o ? '0 : count_q + LOGWIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/serial_deserializer.sv
// rtl/serial_deserializer.sv - serial-to-parallel receiver with one-word output hold; SERIAL_DESERIALIZER_MSB_FIRST_EN selects MSB-first order
module serial_deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH    = 20,
    parameter int LOGWIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_i,
    input  logic             valid_i,
    input  logic             align_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             overflow_o
);

    if (!counter_width_ok(WIDTH, LOGWIDTH)) begin : g_bad_params
        $error("serial_deserializer: WIDTH must be >= 2 and fit in LOGWIDTH bits");
    end

    collect_state_e      state_q, state_d;
    logic [WIDTH-1:0]    sreg_q, sreg_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic                valid_q, valid_d;
    logic                overflow_q, overflow_d;
    logic [WIDTH-1:0]    word;
    logic [LOGWIDTH-1:0] count;
    logic                last;
    logic                complete;
    logic                transfer;

    deser_bit_counter #(
        .WIDTH    (WIDTH),
        .LOGWIDTH (LOGWIDTH)
    ) u_bit_counter (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (valid_i),
        .clear_i (align_i),
        .count_o (count),
        .last_o  (last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_i) state_d = COLLECT;
            COLLECT: if (valid_i && last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (align_i) begin
            state_d = valid_i ? COLLECT : IDLE;
        end
    end

    // word is the partial word with the current bit merged in.
    always_comb begin
        word = sreg_q;
`ifdef SERIAL_DESERIALIZER_MSB_FIRST_EN
        word = {sreg_q[WIDTH-2:0], data_i};
`else
        for (int i = 0; i < WIDTH; i++) begin
            if (count == LOGWIDTH'(i)) begin
                word[i] = data_i;
            end
        end
`endif
        sreg_d   = sreg_q;
        complete = 1'b0;
        if (align_i) begin
            sreg_d = valid_i ? WIDTH'(data_i) : '0;
        end else if (valid_i) begin
            if (last) begin
                complete = 1'b1;
                sreg_d   = '0;
            end else begin
                sreg_d = word;
            end
        end
    end

    // A completing word is dropped only when the held word is stalled.
    always_comb begin
        transfer   = valid_q && ready_i;
        data_d     = data_q;
        valid_d    = valid_q;
        overflow_d = 1'b0;
        if (complete) begin
            if (valid_q && !ready_i) begin
                overflow_d = 1'b1;
            end else begin
                data_d  = word;
                valid_d = 1'b1;
            end
        end else if (transfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign overflow_o = overflow_q;

endmodule
